// File: rtl/tbird_pkg.sv
// rtl/tbird_pkg.sv - shared types, lamp patterns and seven-segment codes for the T-Bird pattern monitor
package tbird_pkg;

    // Decoded sequencer mode
    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_LEFT   = 2'd1,
        MODE_RIGHT  = 2'd2,
        MODE_HAZARD = 2'd3
    } mode_e;

    // Lamp bus: [5:3] = L3..L1 (outermost at [5]), [2:0] = R1..R3 (outermost at [0])
    localparam logic [5:0] PAT_OFF = 6'b000000;
    localparam logic [5:0] PAT_L1  = 6'b001000;
    localparam logic [5:0] PAT_L2  = 6'b011000;
    localparam logic [5:0] PAT_L3  = 6'b111000;
    localparam logic [5:0] PAT_R1  = 6'b000100;
    localparam logic [5:0] PAT_R2  = 6'b000110;
    localparam logic [5:0] PAT_R3  = 6'b000111;
    localparam logic [5:0] PAT_ALL = 6'b111111;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_IDLE   = 7'b0111111;
    localparam logic [6:0] SEG_LEFT   = 7'b1000111;
    localparam logic [6:0] SEG_RIGHT  = 7'b0101111;
    localparam logic [6:0] SEG_HAZARD = 7'b0001001;
    localparam logic [6:0] SEG_ERROR  = 7'b0000110;

    // What a single lamp pattern means on its own, independent of history
    typedef struct packed {
        logic       legal;
        mode_e      mode;
        logic [1:0] step;
    } pat_info_t;

    // Map a raw lamp pattern to mode/step; OFF carries no mode of its own
    function automatic pat_info_t decode_pattern(input logic [5:0] pat);
        pat_info_t info;
        info.legal = 1'b1;
        info.mode  = MODE_IDLE;
        info.step  = 2'd0;
        case (pat)
            PAT_OFF: begin
                info.mode = MODE_IDLE;
                info.step = 2'd0;
            end
            PAT_L1: begin
                info.mode = MODE_LEFT;
                info.step = 2'd1;
            end
            PAT_L2: begin
                info.mode = MODE_LEFT;
                info.step = 2'd2;
            end
            PAT_L3: begin
                info.mode = MODE_LEFT;
                info.step = 2'd3;
            end
            PAT_R1: begin
                info.mode = MODE_RIGHT;
                info.step = 2'd1;
            end
            PAT_R2: begin
                info.mode = MODE_RIGHT;
                info.step = 2'd2;
            end
            PAT_R3: begin
                info.mode = MODE_RIGHT;
                info.step = 2'd3;
            end
            PAT_ALL: begin
                info.mode = MODE_HAZARD;
                info.step = 2'd1;
            end
            default: begin
                info.legal = 1'b0;
            end
        endcase
        return info;
    endfunction

endpackage

// File: rtl/tbird_seg_mode_enc.sv
// rtl/tbird_seg_mode_enc.sv - combinational seven-segment encoder for decoded mode and error state
module tbird_seg_mode_enc
    import tbird_pkg::*;
(
    input  logic [1:0] mode,
    input  logic       err,
    output logic [6:0] seg
);

    // Error glyph takes priority so a fault is never hidden behind a mode letter
    always_comb begin
        seg = SEG_IDLE;
        if (err) begin
            seg = SEG_ERROR;
        end else begin
            case (mode_e'(mode))
                MODE_IDLE:   seg = SEG_IDLE;
                MODE_LEFT:   seg = SEG_LEFT;
                MODE_RIGHT:  seg = SEG_RIGHT;
                MODE_HAZARD: seg = SEG_HAZARD;
                default:     seg = SEG_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/tbird_pattern_monitor.sv
// rtl/tbird_pattern_monitor.sv - lamp-bus sequence checker; TBIRD_MON_TIMING_CHECK_EN enables the min-gap and stall checks
module tbird_pattern_monitor
    import tbird_pkg::*;
#(
    parameter int unsigned MIN_GAP = 1_000_000,
    parameter int unsigned MAX_GAP = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] leds_in,
    input  logic       clear,
    output logic [1:0] mode,
    output logic [1:0] step,
    output logic       change,
    output logic       err_illegal,
    output logic       err_timing,
    output logic [6:0] seg
);

    // Counter must hold either bound so the min-gap compare never truncates
    localparam int unsigned GAP_BOUND = (MAX_GAP > MIN_GAP) ? MAX_GAP : MIN_GAP;
    localparam int          GAP_W     = $clog2(GAP_BOUND + 1);
    localparam logic [GAP_W-1:0] GAP_SAT  = GAP_W'(MAX_GAP);
    // Idle/stall fire on the edge that moves the counter onto MAX_GAP-1
    localparam logic [GAP_W-1:0] GAP_FIRE = GAP_W'(MAX_GAP - 2);
`ifdef TBIRD_MON_TIMING_CHECK_EN
    localparam logic [GAP_W-1:0] GAP_MIN  = GAP_W'(MIN_GAP - 1);
`endif

    logic [5:0]       leds_q, leds_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    mode_e            mode_q, mode_d;
    logic [1:0]       step_q, step_d;
    logic             change_q, change_d;
    logic             err_illegal_q, err_illegal_d;

    logic             pat_changed;
    logic             trans_ok;
    pat_info_t        in_info;
    logic             illegal_hit;
    logic             timing_hit;

    assign pat_changed = (leds_in != leds_q);
    assign in_info     = decode_pattern(leds_in);

    // Which new patterns may follow the previous one; step 2/3 only from its predecessor
    always_comb begin
        trans_ok = 1'b0;
        case (leds_in)
            PAT_OFF, PAT_L1, PAT_R1, PAT_ALL: trans_ok = 1'b1;
            PAT_L2:  trans_ok = (leds_q == PAT_L1);
            PAT_L3:  trans_ok = (leds_q == PAT_L2);
            PAT_R2:  trans_ok = (leds_q == PAT_R1);
            PAT_R3:  trans_ok = (leds_q == PAT_R2);
            default: trans_ok = 1'b0;
        endcase
    end

    // Next-state: change handling, gap counting, idle/stall decisions and error detection
    always_comb begin
        leds_d      = leds_q;
        gap_d       = gap_q;
        mode_d      = mode_q;
        step_d      = step_q;
        change_d    = 1'b0;
        illegal_hit = 1'b0;
        timing_hit  = 1'b0;

        if (pat_changed) begin
            leds_d   = leds_in;
            gap_d    = '0;
            change_d = 1'b1;
            if (in_info.legal && trans_ok) begin
                step_d = in_info.step;
                // OFF keeps the current mode; only the idle timeout returns to IDLE
                if (leds_in != PAT_OFF) begin
                    mode_d = in_info.mode;
                end
            end else begin
                illegal_hit = 1'b1;
            end
`ifdef TBIRD_MON_TIMING_CHECK_EN
            if ((mode_q != MODE_IDLE) && (gap_q < GAP_MIN)) begin
                timing_hit = 1'b1;
            end
`endif
        end else begin
            if (gap_q != GAP_SAT) begin
                gap_d = gap_q + GAP_W'(1);
            end
            // Counter saturates past this value, so this fires once per static episode
            if (gap_q == GAP_FIRE) begin
                if (leds_q == PAT_OFF) begin
                    mode_d = MODE_IDLE;
                end else begin
`ifdef TBIRD_MON_TIMING_CHECK_EN
                    timing_hit = 1'b1;
`endif
                end
            end
        end

        // A fresh error in the clear cycle survives the clear
        err_illegal_d = (err_illegal_q & ~clear) | illegal_hit;
    end

    // Register all monitor state
    always_ff @(posedge clk) begin
        if (rst) begin
            leds_q        <= PAT_OFF;
            gap_q         <= '0;
            mode_q        <= MODE_IDLE;
            step_q        <= 2'd0;
            change_q      <= 1'b0;
            err_illegal_q <= 1'b0;
        end else begin
            leds_q        <= leds_d;
            gap_q         <= gap_d;
            mode_q        <= mode_d;
            step_q        <= step_d;
            change_q      <= change_d;
            err_illegal_q <= err_illegal_d;
        end
    end

`ifdef TBIRD_MON_TIMING_CHECK_EN
    logic err_timing_q, err_timing_d;

    // Sticky timing flag, same clear/override rule as the illegal flag
    always_comb begin
        err_timing_d = (err_timing_q & ~clear) | timing_hit;
    end

    // Register the timing flag
    always_ff @(posedge clk) begin
        if (rst) begin
            err_timing_q <= 1'b0;
        end else begin
            err_timing_q <= err_timing_d;
        end
    end

    assign err_timing = err_timing_q;
`else
    logic unused_timing;
    assign unused_timing = timing_hit;
    assign err_timing    = 1'b0;
`endif

    assign mode        = mode_q;
    assign step        = step_q;
    assign change      = change_q;
    assign err_illegal = err_illegal_q;

    tbird_seg_mode_enc u_seg_enc (
        .mode (mode_q),
        .err  (err_illegal_q | err_timing),
        .seg  (seg)
    );

endmodule

// File: doc/tbird_pattern_monitor.md
# tbird_pattern_monitor

Receive-side checker for the T-Bird tail-light sequencer. Samples the six-lamp `leds` bus driven by the sequencer `top`, decodes mode and step, checks every pattern change against the legal sequence grammar, and drives a seven-segment code naming the decoded mode. It sits beside `top` on the DE10-Lite, on the same 50 MHz clock.

## Interface

**Parameters**
- `MIN_GAP` (default 1_000_000): minimum legal cycles between consecutive pattern changes while mode ≠ IDLE.
- `MAX_GAP` (default 50_000_000): cycles a pattern may stay static before a stall or an idle decision.

**Ports**
- `clk`, input, 1: 50 MHz clock.
- `rst`, input, 1: synchronous, active-high reset.
- `leds_in`, input, 6: sequencer lamp bus. `[5:3]` = left L3..L1, with `[5]` outermost. `[2:0]` = right R1..R3, with `[0]` outermost.
- `clear`, input, 1: clears the sticky error flags.
- `mode`, output, 2: decoded mode. 0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZARD.
- `step`, output, 2: 0 = off phase, 1..3 = lamps lit.
- `change`, output, 1: one-cycle pulse on each detected pattern change.
- `err_illegal`, output, 1: sticky; set by an illegal pattern or an illegal transition.
- `err_timing`, output, 1: sticky; set by a gap that is too short or by a stall.
- `seg`, output, 7: active-low code `{g,f,e,d,c,b,a}`.

## Operation

**Legal patterns**
- OFF `000000`
- L1 `001000`, L2 `011000`, L3 `111000`
- R1 `000100`, R2 `000110`, R3 `000111`
- ALL `111111`
- Any other value is illegal.

**Change detection**
- A change is `leds_in != leds_q`, where `leds_q` is the registered previous sample.

**Legal transitions**
- Any pattern → OFF.
- OFF → L1, R1 or ALL.
- L1 → L2 → L3.
- R1 → R2 → R3.
- Any lit pattern → L1, R1 or ALL (mode switch mid-sequence).

**On a change to a legal pattern**
- L1, L2 or L3: mode = LEFT, step = 1, 2 or 3.
- R1, R2 or R3: mode = RIGHT, step = 1, 2 or 3.
- ALL: mode = HAZARD, step = 1.
- OFF: mode is unchanged, step = 0.

**On an illegal pattern or illegal transition**
- Set `err_illegal`.
- Do not change `mode` or `step`.
- Still update `leds_q`.

**Gap counter**
- Counts cycles since the last change and saturates at `MAX_GAP`.
- Resets to 0 on every change.

**Idle and stall decisions**
- OFF static for `MAX_GAP` cycles → mode = IDLE. This is not an error.
- A lit pattern static for `MAX_GAP` cycles → set `err_timing`, once per static episode.

**Seven-segment codes**
- IDLE `0111111` ("-")
- LEFT `1000111` ("L")
- RIGHT `0101111` ("r")
- HAZARD `0001001` ("H")
- Either error flag set → `0000110` ("E"). This overrides the mode code.

**Clearing errors**
- `clear` clears both sticky flags.
- If a new error is detected in the same cycle as `clear`, the error wins.

## Timing

- **Reset values:** `leds_q` = 0, gap = 0, `mode` = IDLE, `step` = 0, `change` = 0, both errors = 0, `seg` = `0111111`.
- **Latency:** a change present on `leds_in` before edge k is reflected in `mode`, `step`, `change` and the error flags immediately after edge k. All outputs are registered except `seg`, which is a combinational decode of registered state.
- **Minimum gap:** applied when a change occurs with gap < `MIN_GAP − 1` and mode ≠ IDLE.
- **Stall and idle thresholds:** fire on the edge where gap reaches `MAX_GAP − 1` without a change.
- **Reset mid-sequence:** `rst` mid-sequence returns every output to its reset value. The first pattern after reset is judged against OFF.
- **Input timing:** `leds_in` is synchronous to `clk`; no synchroniser is used.

## Configuration

- `TBIRD_MON_TIMING_CHECK_EN` defined: the `MIN_GAP` check and the stall check are compiled in.
- Undefined:
  - `err_timing` is tied to 0.
  - The gap counter is still used only for the IDLE decision.
  - No `MIN_GAP` comparator is built.

## Structure

- **Package `tbird_pkg`:**
  - mode enum (IDLE, LEFT, RIGHT, HAZARD)
  - the eight legal pattern constants
  - the five seg constants
- **Sub-module `tbird_seg_mode_enc`:** combinational decode of mode and error to `seg`.
- **Top `tbird_pattern_monitor`:** holds the legality check, gap counter and sticky flags.

## Test plan

Bench parameters: `MIN_GAP` = 4, `MAX_GAP` = 64, macro defined.

1. **Left sequence.** Drive OFF→L1→L2→L3→OFF, each held 10 cycles. Expect `mode` = 1, `step` 1,2,3,0, four `change` pulses, `seg` = `1000111`, no errors.
2. **Illegal pattern and clear.** After R1, drive `101000`. Expect `err_illegal` = 1 the next cycle, mode stays RIGHT with step 1, `seg` = `0000110`. Then pulse `clear` → errors 0, `seg` = `0101111`.
3. **Gap too short.** Drive L1→L2 with a 2-cycle gap. Expect `err_timing` = 1. Drive R1→R2 with a 10-cycle gap. Expect no timing error.
4. **Stall.** Hold ALL for 70 cycles. Expect `mode` = 3 and `err_timing` set at gap 63. Hold OFF for 70 cycles after clear. Expect `mode` = 0 and no error.
5. **Mode switch and simultaneous clear.** Drive R2→L1 with a 10-cycle gap. Expect a legal change to LEFT. Drive an illegal change in the same cycle as `clear`. Expect `err_illegal` = 1.
6. **Reset.** Assert `rst` during L3. Expect all outputs at reset values next cycle. Then drive L2 directly → `err_illegal` (OFF→L2 is illegal).
